adder_seq_ctrl: RTL

Sequencer and two-port arbiter for the shared 4-bit `full_adder` datapath. It accepts wide additions of `4*NIBBLES` bits from two requesters and grants them round-robin. It then drives the external combinational adder one nibble per cycle, least-significant nibble first, chaining the carry. It returns the full sum and carry-out on a single tagged response channel.

---
 rtl/adder_seq_ctrl_if.sv | 60 ++++++
 rtl/adder_seq_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if
//   Bundle of all handshake and datapath signals around adder_seq_ctrl.
//   Ports grouped here:
//     req0_* / req1_* : two requesters (valid/ready, W-bit operands, carry-in)
//     fa_*            : nibble operands to / result from the external full_adder
//     resp_*          : tagged response channel (valid/ready, id, sum, carry-out)
//   Modports:
//     slave  : the controller side (adder_seq_ctrl)
//     master : the environment side (requesters, consumer, full_adder)
interface adder_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;

    logic [3:0]   fa_a;
    logic [3:0]   fa_b;
    logic         fa_cin;
    logic [3:0]   fa_sum;
    logic         fa_cout;

    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic [W-1:0] resp_sum;
    logic         resp_cout;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output fa_a, fa_b, fa_cin,
        input  fa_sum, fa_cout,
        output resp_valid, resp_id, resp_sum, resp_cout,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  fa_a, fa_b, fa_cin,
        output fa_sum, fa_cout,
        input  resp_valid, resp_id, resp_sum, resp_cout,
        output resp_ready
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl
//   Sequencer and round-robin two-port arbiter for a shared external 4-bit
//   full_adder. A W-bit (W = 4*NIBBLES) addition is accepted from one of two
//   requesters, driven through the adder one nibble per cycle (LSB nibble
//   first, carry chained), and returned as sum + carry-out tagged with the
//   requester index.
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous active-high reset
//     bus : adder_seq_ctrl_if.slave (requesters, full_adder, response)
module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic            clk,
    input logic            rst,
    adder_seq_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          carry;
    logic [IW-1:0] idx;
    logic [W-1:0]  sum_r;
    logic          owner;
    logic          last;

    logic sel0, sel1, idle;

    // On conflict the requester that was not served last wins; a lone
    // requester always wins. Readies are masked during reset.
    always_comb begin
        idle = (state == IDLE) && !rst;
        sel0 = bus.req0_valid && (!bus.req1_valid || last);
        sel1 = bus.req1_valid && (!bus.req0_valid || !last);
        bus.req0_ready = idle && sel0;
        bus.req1_ready = idle && sel1;
    end

    // The adder is combinational, so its operands come straight from the
    // current nibble and its result is captured on the same edge.
    always_comb begin
        bus.fa_a   = '0;
        bus.fa_b   = '0;
        bus.fa_cin = 1'b0;
        if (state == RUN) begin
            bus.fa_a   = op_a[{idx, 2'b00} +: 4];
            bus.fa_b   = op_b[{idx, 2'b00} +: 4];
            bus.fa_cin = carry;
        end
    end

    always_comb begin
        bus.resp_valid = (state == DONE);
        bus.resp_sum   = (state == DONE) ? sum_r : '0;
        bus.resp_cout  = (state == DONE) ? carry : 1'b0;
        bus.resp_id    = (state == DONE) ? owner : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum_r <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0_ready) begin
                        op_a  <= bus.req0_a;
                        op_b  <= bus.req0_b;
                        carry <= bus.req0_cin;
                        owner <= 1'b0;
                        idx   <= '0;
                        sum_r <= '0;
                        state <= RUN;
                    end else if (bus.req1_ready) begin
                        op_a  <= bus.req1_a;
                        op_b  <= bus.req1_b;
                        carry <= bus.req1_cin;
                        owner <= 1'b1;
                        idx   <= '0;
                        sum_r <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r[{idx, 2'b00} +: 4] <= bus.fa_sum;
                    carry                    <= bus.fa_cout;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        last  <= owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
